// File: rtl/pkt_commit_pkg.sv
// ============================================================================
// Package     : pkt_commit_pkg
// Description : Shared types and helpers for the packet commit buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkt_commit_pkg;

  // Data width of the reference beat record
  localparam int BEAT_DATA_W = 32;

  // Width of the saturating statistics counters
  localparam int STAT_W = 16;

  // One stored beat: payload plus its framing flags
  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   sop;
    logic                   eop;
  } beat_t;

  // Input framing state
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_PKT  = 2'd1,
    DISCARD = 2'd2
  } fsm_e;

  // Pointer width: one extra bit beyond the address so full and empty differ
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_commit_ram.sv
// ============================================================================
// Module      : pkt_commit_ram
// Description : Simple dual-port beat storage, one write port, one read port
//               with a registered read that holds its value while idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_commit_ram #(
  parameter int WIDTH  = 34,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write; contents are not reset, pointers make them invisible
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the show-ahead output register of the top level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/packet_commit_buffer.sv
// ============================================================================
// Module      : packet_commit_buffer
// Description : Store-and-forward packet buffer. Packets become readable only
//               once their end beat is written; overflowing or badly framed
//               packets are discarded whole.
//               Optional macro PKT_COMMIT_STATS_EN adds saturating
//               pkt_count / drop_count / err_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_commit_buffer
  import pkt_commit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_startofpacket,
  input  logic              in_endofpacket,
  output logic [DATA_W-1:0] out_data,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              drop_pulse,
  output logic              err_pulse
`ifdef PKT_COMMIT_STATS_EN
  ,
  output logic [STAT_W-1:0] pkt_count,
  output logic [STAT_W-1:0] drop_count,
  output logic [STAT_W-1:0] err_count
`endif
);

  localparam int              PTR_W   = ptr_w(DEPTH);
  localparam int              ADDR_W  = PTR_W - 1;
  localparam int              BEAT_W  = DATA_W + 2;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  fsm_e             state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] commit_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [PTR_W-1:0] wr_base;
  logic [PTR_W-1:0] used_base;
  logic             live;
  logic             overflow;
  logic             wr_en;
  logic             commit;
  logic             framing_err;
  logic             avail;
  logic             rd_en;
  logic [BEAT_W-1:0] rd_beat;

  // Decode the current input beat against the framing state and occupancy
  always_comb begin
    // A sop while a packet is open abandons it: the new beat lands at commit_ptr
    wr_base     = (state == IN_PKT && in_startofpacket) ? commit_ptr : wr_ptr;
    live        = in_startofpacket || (state == IN_PKT);
    used_base   = wr_base - rd_ptr;
    overflow    = live && (used_base == DEPTH_P);
    wr_en       = live && !overflow;
    commit      = wr_en && in_endofpacket;
    framing_err = (state == IDLE && in_endofpacket && !in_startofpacket) ||
                  (state == IN_PKT && in_startofpacket);
    avail       = (commit_ptr != rd_ptr);
    rd_en       = avail && (!out_valid || out_ready);
  end

  // Framing FSM, pointer bookkeeping and event pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      drop_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      drop_pulse <= overflow;
      err_pulse  <= framing_err;
      if (overflow) begin
        wr_ptr <= commit_ptr;
        state  <= in_endofpacket ? IDLE : DISCARD;
      end else if (wr_en) begin
        wr_ptr <= wr_base + ONE_P;
        if (in_endofpacket) begin
          commit_ptr <= wr_base + ONE_P;
          state      <= IDLE;
        end else begin
          state      <= IN_PKT;
        end
      end else if (state == DISCARD && in_endofpacket) begin
        state <= IDLE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
    end
  end

  // Output valid tracks the show-ahead register; it holds while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= avail;
    end
  end

  pkt_commit_ram #(
    .WIDTH  (BEAT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_base[ADDR_W-1:0]),
    .wr_data ({in_data, in_startofpacket, in_endofpacket}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_beat)
  );

  assign out_data          = rd_beat[BEAT_W-1:2];
  assign out_startofpacket = rd_beat[1];
  assign out_endofpacket   = rd_beat[0];

`ifdef PKT_COMMIT_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  // Saturating event counters; simultaneous events each count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count  <= '0;
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      if (commit && pkt_count != STAT_MAX) begin
        pkt_count <= pkt_count + STAT_ONE;
      end
      if (overflow && drop_count != STAT_MAX) begin
        drop_count <= drop_count + STAT_ONE;
      end
      if (framing_err && err_count != STAT_MAX) begin
        err_count <= err_count + STAT_ONE;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_packet_commit_buffer.sv
// ============================================================================
// Module      : tb_packet_commit_buffer
// Description : Self-checking bench for packet_commit_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_commit_buffer;
  import pkt_commit_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_startofpacket = 1'b0;
  logic              in_endofpacket = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              drop_pulse;
  logic              err_pulse;
`ifdef PKT_COMMIT_STATS_EN
  logic [15:0]       pkt_count;
  logic [15:0]       drop_count;
  logic [15:0]       err_count;
`endif

  packet_commit_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .drop_pulse        (drop_pulse),
    .err_pulse         (err_pulse)
`ifdef PKT_COMMIT_STATS_EN
    ,
    .pkt_count         (pkt_count),
    .drop_count        (drop_count),
    .err_count         (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model state ----------------
  beat_t exp_q[$];          // beats the sink must see, in order
  bit    mon_en     = 1'b0;
  bit    rand_ready = 1'b0;
  bit    valid_seen = 1'b0;
  int    drop_seen  = 0;
  int    err_seen   = 0;

  task automatic clear_obs();
    drop_seen  = 0;
    err_seen   = 0;
    valid_seen = 1'b0;
  endtask

  // Output monitor: every accepted beat must be the next expected beat
  always @(negedge clk) begin
    if (!reset) begin
      if (drop_pulse) drop_seen++;
      if (err_pulse)  err_seen++;
      if (out_valid)  valid_seen = 1'b1;
      if (mon_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", {30'b0, out_data, out_startofpacket, out_endofpacket}, 64'h0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check(out_data == e.data && out_startofpacket == e.sop && out_endofpacket == e.eop,
                "out_beat", {30'b0, out_data, out_startofpacket, out_endofpacket},
                {30'b0, e.data, e.sop, e.eop});
        end
      end
    end
  end

  // One input beat per call, changed just after the active edge
  task automatic drive(input logic s, input logic e, input logic [31:0] d);
    @(posedge clk);
    #1;
    in_startofpacket = s;
    in_endofpacket   = e;
    in_data          = d;
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic push_beat(input logic [31:0] d, input logic s, input logic e);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e;
    exp_q.push_back(b);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    check(exp_q.size() == 0, name, 64'(exp_q.size()), 64'h0);
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic        sop, eop;
    logic [31:0] data;
    logic        ready;
    logic        e_valid, e_sop, e_eop;
    logic [31:0] e_data;
    logic        e_err, e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic e, input logic [31:0] d, input logic r,
                              input logic ev, input logic es, input logic ee, input logic [31:0] ed,
                              input logic er, input logic dr);
    vec_t v;
    v.sop = s; v.eop = e; v.data = d; v.ready = r;
    v.e_valid = ev; v.e_sop = es; v.e_eop = ee; v.e_data = ed; v.e_err = er; v.e_drop = dr;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] act, exp;
    int err_exp;
    int good;
    bit prev_broken;

    // 3-word packet, single-beat packet, stray eop, stalled single beat
    vecs.push_back(mk(1, 0, 32'hA1,   1, 0, 0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 0, 32'hA2,   1, 0, 0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 1, 32'hA3,   1, 0, 0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1, 0, 32'hA1,   0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 0, 0, 32'hA2,   0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 0, 1, 32'hA3,   0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(1, 1, 32'hDEAD, 1, 0, 0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1, 1, 32'hDEAD, 0, 0));
    vecs.push_back(mk(0, 1, 32'h55,   1, 0, 0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(1, 1, 32'h77,   0, 0, 0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1, 1, 32'h77,   0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1, 1, 32'h77,   0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    0, 0));

    // Reset state
    repeat (3) @(negedge clk);
    check({out_valid, out_startofpacket, out_endofpacket, drop_pulse, err_pulse} == 5'b0 && out_data == '0,
          "reset_state", {27'b0, out_data, out_valid, out_startofpacket, out_endofpacket, drop_pulse, err_pulse}, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      in_startofpacket = vecs[i].sop;
      in_endofpacket   = vecs[i].eop;
      in_data          = vecs[i].data;
      out_ready        = vecs[i].ready;
      @(posedge clk);
      @(negedge clk);
      act = '0;
      exp = '0;
      act[37:0] = {out_valid ? out_data : 32'h0, out_valid,
                   out_valid & out_startofpacket, out_valid & out_endofpacket, err_pulse, drop_pulse, 1'b0};
      exp[37:0] = {vecs[i].e_valid ? vecs[i].e_data : 32'h0, vecs[i].e_valid,
                   vecs[i].e_sop, vecs[i].e_eop, vecs[i].e_err, vecs[i].e_drop, 1'b0};
      check(act == exp, $sformatf("table_row%0d", i), act, exp);
    end
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_data          = '0;
    mon_en           = 1'b1;

    // Oversized packet is dropped whole; a following packet survives
    out_ready = 1'b0;
    clear_obs();
    drive(1'b1, 1'b0, 32'h3000);
    for (int k = 1; k < 69; k++) drive(1'b0, 1'b0, 32'h3000 + 32'(k));
    drive(1'b0, 1'b1, 32'h3000 + 32'd69);
    repeat (3) drive(1'b0, 1'b0, 32'h0);
    check(drop_seen == 1, "overflow_drop_count", 64'(drop_seen), 64'd1);
    check(valid_seen == 1'b0, "overflow_no_valid", 64'(valid_seen), 64'd0);
    for (int k = 0; k < 4; k++) push_beat(32'h4000 + 32'(k), k == 0, k == 3);
    for (int k = 0; k < 4; k++) drive(k == 0, k == 3, 32'h4000 + 32'(k));
    drive(1'b0, 1'b0, 32'h0);
    out_ready = 1'b1;
    drain("after_overflow_drain");
    check(err_seen == 0, "overflow_no_err", 64'(err_seen), 64'd0);

    // Restarted packet: only the second packet emerges, one framing error
    clear_obs();
    for (int k = 0; k < 3; k++) push_beat(32'hC0 + 32'(k), k == 0, k == 2);
    drive(1'b1, 1'b0, 32'hB0);
    drive(1'b0, 1'b0, 32'hB1);
    drive(1'b0, 1'b0, 32'hB2);
    drive(1'b1, 1'b0, 32'hC0);
    drive(1'b0, 1'b0, 32'hC1);
    drive(1'b0, 1'b1, 32'hC2);
    drain("restart_drain");
    check(err_seen == 1, "restart_err_count", 64'(err_seen), 64'd1);
    check(drop_seen == 0, "restart_no_drop", 64'(drop_seen), 64'd0);

    // Reset mid-packet with a committed packet waiting
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) drive(k == 0, k == 9, 32'h5000 + 32'(k));
    repeat (3) drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check(out_valid == 1'b1, "valid_before_reset", 64'(out_valid), 64'd1);
    drive(1'b1, 1'b0, 32'h6000);
    drive(1'b0, 1'b0, 32'h6001);
    drive(1'b0, 1'b0, 32'h6002);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check(out_valid == 1'b0 && drop_pulse == 1'b0 && err_pulse == 1'b0, "async_reset_outputs",
          {61'b0, out_valid, drop_pulse, err_pulse}, 64'h0);
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_obs();
    out_ready = 1'b1;
    repeat (20) drive(1'b0, 1'b0, 32'h0);
    check(valid_seen == 1'b0, "nothing_after_reset", 64'(valid_seen), 64'd0);

    // Randomised traffic with random sink stalls and injected framing faults
    clear_obs();
    rand_ready  = 1'b1;
    err_exp     = 0;
    good        = 0;
    prev_broken = 1'b0;
    for (int p = 0; p < 150; p++) begin
      int  len;
      int  kind;
      bit  broken;
      len    = $urandom_range(1, 5);
      kind   = $urandom_range(0, 9);
      broken = (kind == 0) && !prev_broken && (p < 149);
      if (!prev_broken) begin
        for (int w = 0; w < 2000 && exp_q.size() + 10 > DEPTH; w++) drive(1'b0, 1'b0, 32'h0);
        if (exp_q.size() + 10 > DEPTH) check(1'b0, "throttle_timeout", 64'(exp_q.size()), 64'd54);
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 32'h0);
        if (kind == 1) begin
          drive(1'b0, 1'b1, 32'hBAD);
          err_exp++;
        end
      end
      if (broken) begin
        // abandoned by the next packet's sop
        for (int k = 0; k < len; k++) drive(k == 0, 1'b0, $urandom);
        err_exp++;
      end else begin
        for (int k = 0; k < len; k++) begin
          logic [31:0] d;
          d = $urandom;
          push_beat(d, k == 0, k == len - 1);
          drive(k == 0, k == len - 1, d);
        end
        good++;
      end
      prev_broken = broken;
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain("random_drain");
    check(err_seen == err_exp, "random_err_count", 64'(err_seen), 64'(err_exp));
    check(drop_seen == 0, "random_no_drop", 64'(drop_seen), 64'd0);
`ifdef PKT_COMMIT_STATS_EN
    check(pkt_count == 16'(good), "stats_pkt_count", 64'(pkt_count), 64'(good));
    check(err_count == 16'(err_exp), "stats_err_count", 64'(err_count), 64'(err_exp));
    check(drop_count == 16'd0, "stats_drop_count", 64'(drop_count), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
